// File: rtl/sadc_pkg.sv
// Shared types and constants for the successive-approximation ADC model.
package sadc_pkg;

  localparam int unsigned NBITS       = 8;
  localparam int          FS_CODE     = 127;
  localparam int          CODE_OFFSET = 128;

  // Encoding order matters: bit_of() derives the bit under trial from it.
  typedef enum logic [3:0] {
    StSample = 4'd0,
    StBit7   = 4'd1,
    StBit6   = 4'd2,
    StBit5   = 4'd3,
    StBit4   = 4'd4,
    StBit3   = 4'd5,
    StBit2   = 4'd6,
    StBit1   = 4'd7,
    StBit0   = 4'd8
  } state_e;

  function automatic logic [2:0] bit_of(state_e s);
    logic [3:0] idx;
    idx = 4'd8 - 4'(s);
    return idx[2:0];
  endfunction

endpackage

// File: rtl/sadc_dac.sv
// Ideal DAC: maps an offset-binary trial code to its comparison threshold.
module sadc_dac
  import sadc_pkg::*;
#(
  parameter real VREF = 1.0
) (
  input  logic [NBITS-1:0] code,
  output real              threshold
);

  always_comb begin
    threshold = (real'(int'(code)) - real'(CODE_OFFSET)) / real'(FS_CODE) * VREF;
  end

endmodule

// File: rtl/sadc.sv
// Free-running 8-bit SAR ADC: one sample state followed by one state per result bit.
module sadc
  import sadc_pkg::*;
#(
  parameter real VREF = 1.0
) (
  input  logic              clk,
  input  logic              rstn,
  input  real               ana_in,
  output logic signed [7:0] dig_out
);

  state_e            state_q, state_d;
  logic [NBITS-1:0]  trial_q, trial_d;
  real               hold_q, hold_d;
  logic signed [7:0] dig_d;
  real               thresh;
  logic [2:0]        k;
  logic [NBITS-1:0]  cur_mask;

  sadc_dac #(
    .VREF(VREF)
  ) u_dac (
    .code     (trial_q),
    .threshold(thresh)
  );

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    hold_d   = hold_q;
    dig_d    = dig_out;
    k        = bit_of(state_q);
    cur_mask = NBITS'(1) << k;

    if (state_q == StSample) begin
      hold_d  = ana_in;
      trial_d = 8'b1000_0000;
      state_d = StBit7;
    end else begin
      if (hold_q < thresh) begin
        trial_d = trial_d & ~cur_mask;
      end
      // Shifting the current mask right arms the next bit; it is empty for bit 0.
      trial_d = trial_d | (cur_mask >> 1);
      if (state_q == StBit0) begin
        state_d = StSample;
        dig_d   = {~trial_d[7], trial_d[6:0]};
      end else begin
        state_d = state_e'(state_q + 4'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StSample;
      trial_q <= '0;
      hold_q  <= 0.0;
      dig_out <= '0;
    end else begin
      state_q <= state_d;
      trial_q <= trial_d;
      hold_q  <= hold_d;
      dig_out <= dig_d;
    end
  end

endmodule

// File: tb/tb_sadc.sv
// Scoreboard bench for sadc: a driver queues expected codes, a monitor checks dig_out.
module tb_sadc;

  localparam real VREF = 1.0;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  real               ana_in = 0.0;
  logic signed [7:0] dig_out;

  typedef struct {
    int code;
    int due;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  bit   rst_last = 1'b0;
  bit   have_last = 1'b0;
  int   last_exp = 0;
  int   checks = 0;
  int   errors = 0;

  sadc #(
    .VREF(VREF)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .ana_in (ana_in),
    .dig_out(dig_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_n   <= edge_n + 1;
    rst_last <= !rstn;
  end

  function automatic int ref_code(real v);
    real r;
    r = $floor(v * real'(127) / VREF);
    if (r > 127.0) r = 127.0;
    if (r < -128.0) r = -128.0;
    return $rtoi(r);
  endfunction

  task automatic check(input string name, input int exp);
    checks++;
    if (int'(dig_out) != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: dig_out=%0d expected=%0d", name, edge_n, dig_out, exp);
    end
  endtask

  // Monitor: the result is due at the negedge following the BIT0 edge.
  always @(negedge clk) begin
    if (rst_last) begin
      check("reset", 0);
      have_last = 1'b1;
      last_exp  = 0;
    end else if (sb.size() > 0 && sb[0].due == edge_n) begin
      exp_t e;
      e = sb.pop_front();
      check("conv", e.code);
      last_exp = e.code;
    end else if (have_last) begin
      check("hold", last_exp);
    end
  end

  function automatic real rand_volt();
    return (real'($urandom_range(0, 2400)) - 1200.0) / 1000.0;
  endfunction

  // Called at a negedge just before a sample edge; returns at the next one.
  task automatic conv(input real v);
    exp_t e;
    ana_in = v;
    e.code = ref_code(v);
    e.due  = edge_n + 9;
    sb.push_back(e);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ana_in = rand_volt();
      @(negedge clk);
    end
  endtask

  real directed[$] = '{0.6, -0.6, 0.9, 0.81, 0.0, 1.5, -1.5, 1.0, -1.0};

  initial begin
    rstn   = 1'b0;
    ana_in = 0.7;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    foreach (directed[i]) conv(directed[i]);

    // Back-to-back pair with a changing input between sample edges.
    conv(0.6);
    conv(-0.6);

    // Abort a conversion with reset on the BIT4 edge.
    ana_in = 0.3;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    conv(-0.6);
    conv(0.45);

    for (int i = 0; i < 30; i++) conv(rand_volt());

    // Constant input: several conversions in a row.
    for (int i = 0; i < 3; i++) conv(0.25);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
